// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file.
//   Byte-masked writes, optional same-cycle write-to-read bypass, optional
//   hardwired zero entry, asynchronous reset of every entry, and a Clear
//   sweep that zeroes one entry per cycle while Busy is high.
// Ports:
//   clock, reset_n        single clock, async active-low reset
//   ReadAddr  [NR*AW]     read port k address at [k*AW +: AW]
//   ReadData  [NR*W]      read port k data at [k*W +: W] (combinational)
//   WriteReg/WriteData/WriteMask/RegWrite   byte-masked write request
//   Clear                 starts the clear sweep (taken only when idle)
//   Busy                  high while the sweep runs
module regfile_mp #(
  parameter int unsigned W        = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NR       = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NR*AW-1:0]   ReadAddr,
  output logic [NR*W-1:0]    ReadData,
  input  logic [AW-1:0]      WriteReg,
  input  logic [W-1:0]       WriteData,
  input  logic [W/8-1:0]     WriteMask,
  input  logic               RegWrite,
  input  logic               Clear,
  output logic               Busy
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam int unsigned   NB    = W / 8;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [W-1:0]    r_mem [DEPTH];
  logic            w_busy;
  logic            w_zero_wr;
  logic            w_acc;
  logic [W-1:0]    w_old;
  logic [W-1:0]    w_merged;

  // State register and sweep counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter wraps to 0 on the edge that clears the last entry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (Clear) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the state register only
  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_CLEAR) begin
      w_busy = 1'b1;
    end
  end

  assign Busy = w_busy;

  // Write acceptance: dropped while sweeping, and entry 0 is read-only when hardwired
  assign w_zero_wr = (ZERO_REG != 0) && (WriteReg == '0);
  assign w_acc     = RegWrite && !w_busy && !w_zero_wr;
  assign w_old     = r_mem[WriteReg];

  // Byte merge of new data over the stored word
  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign w_merged[b*8 +: 8] = WriteMask[b] ? WriteData[b*8 +: 8] : w_old[b*8 +: 8];
  end

  // Storage array: async clear of all entries, sweep clear, or masked write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_acc) begin
      r_mem[WriteReg] <= w_merged;
    end
  end

  // Read ports: zero entry, then bypass of an accepted write, then stored value
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_is_zero;
    logic          w_hit;
    assign w_ra      = ReadAddr[k*AW +: AW];
    assign w_is_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit     = (BYPASS != 0) && w_acc && (w_ra == WriteReg);
    assign ReadData[k*W +: W] = w_is_zero ? '0 :
                                w_hit     ? w_merged : r_mem[w_ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp.
//   Two instances share stimulus: A (ZERO_REG=1, BYPASS=1) and B (ZERO_REG=0, BYPASS=0).
//   A word-level model (array per instance plus a countdown of remaining sweep
//   entries) predicts every read port and Busy each cycle; literal pins taken
//   from hand-worked values anchor the model.
module tb_regfile_mp;

  localparam int DEPTH = 32;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic [9:0]  ReadAddr  = '0;
  logic [4:0]  WriteReg  = '0;
  logic [31:0] WriteData = '0;
  logic [3:0]  WriteMask = '0;
  logic        RegWrite  = 1'b0;
  logic        Clear     = 1'b0;
  logic [63:0] rd_a, rd_b;
  logic        busy_a, busy_b;

  always #5 clock = ~clock;

  regfile_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .ReadAddr(ReadAddr), .ReadData(rd_a),
    .WriteReg(WriteReg), .WriteData(WriteData), .WriteMask(WriteMask),
    .RegWrite(RegWrite), .Clear(Clear), .Busy(busy_a)
  );

  regfile_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .ReadAddr(ReadAddr), .ReadData(rd_b),
    .WriteReg(WriteReg), .WriteData(WriteData), .WriteMask(WriteMask),
    .RegWrite(RegWrite), .Clear(Clear), .Busy(busy_b)
  );

  // ---------------- model ----------------
  logic [31:0] m_mem [2][DEPTH];
  int          sweep_left = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Instance 0 has the hardwired zero entry
  function automatic logic m_acc(input int d);
    return RegWrite && (sweep_left == 0) && !(d == 0 && WriteReg == 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input int d, input int k);
    logic [4:0] a;
    a = ReadAddr[k*5 +: 5];
    if (d == 0 && a == 5'd0) return 32'd0;
    if (d == 0 && m_acc(0) && a == WriteReg)
      return merge(m_mem[0][WriteReg], WriteData, WriteMask);
    return m_mem[d][a];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < DEPTH; i++) m_mem[d][i] = 32'd0;
      sweep_left = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (sweep_left > 0) m_mem[d][DEPTH - sweep_left] = 32'd0;
        else if (m_acc(d)) m_mem[d][WriteReg] = merge(m_mem[d][WriteReg], WriteData, WriteMask);
      end
      if (sweep_left > 0) sweep_left = sweep_left - 1;
      else if (Clear) sweep_left = DEPTH;
    end
  end

  // ---------------- checking ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        started  = 1'b0;
  int          pin_n    = 0;
  int          pin_dut  [8];
  int          pin_port [8];
  logic [31:0] pin_val  [8];
  string       pin_name [8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_val(input int d, input int p);
    if (p == 2) return (d == 0) ? 32'(busy_a) : 32'(busy_b);
    return (d == 0) ? rd_a[p*32 +: 32] : rd_b[p*32 +: 32];
  endfunction

  always @(negedge clock) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++)
          cmp($sformatf("model_dut%0d_rd%0d", d, k), dut_val(d, k), model_read(d, k));
        cmp($sformatf("model_dut%0d_busy", d), dut_val(d, 2), 32'(sweep_left != 0));
      end
      for (int i = 0; i < pin_n; i++)
        cmp(pin_name[i], dut_val(pin_dut[i], pin_port[i]), pin_val[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
    pin_n    = 0;
    RegWrite = 1'b0;
    Clear    = 1'b0;
  endtask

  task automatic pin(input int d, input int p, input logic [31:0] v, input string n);
    pin_dut[pin_n]  = d;
    pin_port[pin_n] = p;
    pin_val[pin_n]  = v;
    pin_name[pin_n] = n;
    pin_n++;
  endtask

  task automatic wr(input int a, input logic [31:0] v, input logic [3:0] m);
    WriteReg  = 5'(a);
    WriteData = v;
    WriteMask = m;
    RegWrite  = 1'b1;
  endtask

  task automatic rd(input int a0, input int a1);
    ReadAddr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    started = 1'b1;
    pin(0, 2, 32'd0, "t1_busy_in_reset");
    step();
    reset_n = 1'b1;

    // T1: every entry reads zero after reset
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, DEPTH - 1 - a);
      if (a == 0)  pin(0, 2, 32'd0, "t1_busy_idle");
      if (a == 5)  pin(1, 0, 32'd0, "t1_b_r5_zero");
      if (a == 31) pin(1, 1, 32'd0, "t1_b_r0_zero");
      step();
    end

    // T2: masked byte update
    wr(5, 32'hDEADBEEF, 4'b1111); rd(5, 5);
    pin(0, 0, 32'hDEADBEEF, "t2_a_bypass_full");
    pin(1, 0, 32'd0,        "t2_b_old_value");
    step();
    wr(5, 32'h00001200, 4'b0010); rd(5, 5);
    pin(0, 0, 32'hDEAD12EF, "t2_a_bypass_merge");
    pin(1, 1, 32'hDEADBEEF, "t2_b_stored_value");
    step();
    rd(5, 5);
    pin(0, 0, 32'hDEAD12EF, "t2_a_r5_merged");
    pin(1, 0, 32'hDEAD12EF, "t2_b_r5_merged");
    step();

    // T3: bypass to both ports on the same address
    wr(7, 32'h11223344, 4'b1111); rd(7, 7);
    pin(0, 0, 32'h11223344, "t3_a_p0_bypass");
    pin(0, 1, 32'h11223344, "t3_a_p1_bypass");
    pin(1, 0, 32'd0,        "t3_b_p0_old");
    pin(1, 1, 32'd0,        "t3_b_p1_old");
    step();
    rd(7, 7);
    pin(1, 0, 32'h11223344, "t3_b_p0_next");
    pin(1, 1, 32'h11223344, "t3_b_p1_next");
    step();

    // T4: hardwired versus ordinary entry 0
    wr(0, 32'hFFFFFFFF, 4'b1111); rd(0, 0);
    pin(0, 0, 32'd0, "t4_a_r0_same");
    pin(1, 0, 32'd0, "t4_b_r0_same");
    step();
    rd(0, 0);
    pin(0, 0, 32'd0,        "t4_a_r0_zero");
    pin(1, 0, 32'hFFFFFFFF, "t4_b_r0_written");
    step();

    // T5: fill, then sweep with a dropped write and an ignored re-Clear
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, 32'(i + 1), 4'b1111);
      rd(i, (i + 31) % DEPTH);
      step();
    end
    rd(31, 1);
    pin(1, 0, 32'h20, "t5_b_r31_filled");
    pin(1, 1, 32'h2,  "t5_b_r1_filled");
    pin(0, 1, 32'h2,  "t5_a_r1_filled");
    step();
    Clear = 1'b1; rd(0, 0);
    pin(0, 2, 32'd0, "t5_busy_before_sweep");
    step();
    for (int c = 1; c <= 33; c++) begin
      rd((c + 30) % DEPTH, (c + 31) % DEPTH);
      if (c == 5)  begin wr(3, 32'hAA, 4'b1111); pin(0, 0, 32'd0, "t5_a_no_bypass_busy"); end
      if (c == 15) Clear = 1'b1;
      if (c == 1)  begin pin(0, 2, 32'd1, "t5_a_busy_first"); pin(1, 2, 32'd1, "t5_b_busy_first"); end
      if (c == 10) begin pin(1, 0, 32'd0, "t5_b_r8_swept"); pin(1, 1, 32'd10, "t5_b_r9_pending"); end
      if (c == 32) begin
        pin(0, 2, 32'd1,  "t5_a_busy_last");
        pin(1, 0, 32'd0,  "t5_b_r30_swept");
        pin(1, 1, 32'h20, "t5_b_r31_pending");
      end
      if (c == 33) begin pin(0, 2, 32'd0, "t5_a_busy_done"); pin(1, 2, 32'd0, "t5_b_busy_done"); end
      step();
    end
    rd(3, 31);
    pin(0, 0, 32'd0, "t5_a_r3_dropped");
    pin(1, 0, 32'd0, "t5_b_r3_dropped");
    pin(1, 1, 32'd0, "t5_b_r31_swept");
    step();
    rd(1, 2);
    pin(1, 0, 32'd0, "t5_b_r1_swept");
    pin(0, 2, 32'd0, "t5_a_busy_stays_low");
    step();

    // T6: reset in the middle of a sweep
    wr(4, 32'h77, 4'b1111); step();
    wr(9, 32'h99, 4'b1111); step();
    Clear = 1'b1; step();
    for (int c = 1; c < 10; c++) begin
      rd(9, 4);
      if (c == 9) pin(1, 0, 32'h99, "t6_b_r9_before_reset");
      step();
    end
    rd(9, 4);
    reset_n = 1'b0;
    pin(0, 2, 32'd0, "t6_a_busy_reset");
    pin(1, 2, 32'd0, "t6_b_busy_reset");
    pin(1, 0, 32'd0, "t6_b_r9_reset");
    step();
    reset_n = 1'b1;
    rd(4, 9);
    step();
    wr(4, 32'h55, 4'b1111); rd(4, 4);
    pin(0, 0, 32'h55, "t6_a_r4_bypass");
    pin(1, 0, 32'd0,  "t6_b_r4_old");
    step();
    rd(4, 9);
    pin(0, 0, 32'h55, "t6_a_r4_written");
    pin(1, 0, 32'h55, "t6_b_r4_written");
    pin(0, 2, 32'd0,  "t6_a_busy_idle");
    step();

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
